mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single tiny16 memory port between the CPU controller (fetch, indirect loads and operands) and a DMA/IO requester. It sits between both requesters and the memory. It serialises accesses through a small FSM with round-robin fairness and an optional CPU lock. It returns read data and a one-cycle acknowledge to the requester that owned each access.

## Interface
- AW, 16, address width
- DW, 16, data width
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_lock  in  1  while high, and CPU was last owner, DMA is not granted
- cpu_ack  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  DW  read data, valid in the cpu_ack cycle and held until next CPU read ack
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request bundle; same rules as CPU
- dma_ack  out  1  one-cycle pulse: DMA access complete
- dma_rdata  out  DW  as cpu_rdata, for DMA
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  synchronous read data, valid the cycle after the mem_en cycle
- owner  out  1  0 = CPU, 1 = DMA; owner of the current/last access
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample requests at posedge.
  - No request: stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata into mem_*, set owner, go to ACCESS.
- ACCESS: mem_en=1 for this cycle only. Next state is always RESP.
- RESP: at posedge, capture mem_rdata into owner's rdata (reads only) and pulse owner's ack for the following cycle. Then arbitrate again with the current owner excluded, since its req is still high and stale.
  - Other requester pending and eligible: go to ACCESS with it.
  - Otherwise: go to IDLE.
- Winner selection when both request: the requester not served last wins (round-robin).
- Lock: if cpu_lock=1 and last owner was CPU, the DMA request is masked and the CPU always wins. Lock never preempts an access in flight.
- Writes: ack pulses as for reads; rdata is unchanged.
- A requester that drops req before its ack still completes its access and receives the ack.
- Request inputs are ignored outside arbitration edges. Changes to addr/wdata after the grant edge have no effect.

## Timing
- Reset (rst low, async):
  - state=IDLE; last owner=DMA, so the CPU wins the first tie.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, owner=0, busy=0.
- Reset mid-access: the access is aborted, no ack is issued, mem_en drops immediately.
- Latency: req high at posedge k (IDLE) → mem_en in cycle k..k+1 → ack in cycle k+2..k+3. Read-to-ack is 2 cycles.
- Back-to-back alternating owners: one access per 2 cycles, with no IDLE between them.
- Same requester repeating: it is excluded at the RESP edge, so its minimum spacing is 3 cycles (through IDLE).
- Simultaneous req from both in IDLE: exactly one mem_en. The loser is granted at the RESP edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `bus_defs.v` (included, like `step.v`) holds:
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - requester IDs OWN_CPU=1'b0, OWN_DMA=1'b1.
- One sub-module, `rr_pick`: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last, exclude_valid, exclude_id, lock.
  - Outputs: valid, id.
  - Instantiated once; it is used at both the IDLE and RESP arbitration edges.

## Test plan
- Reset then CPU read: mem holds 0x1234 at 0x0040; cpu_req, addr 0x0040 → mem_en 1 cycle later, cpu_ack 2 cycles after req, cpu_rdata=0x1234, dma_ack never pulses.
- Simultaneous first request: both read out of reset → CPU served first, DMA mem_en on the cycle after the CPU's RESP edge, acks exactly 2 cycles apart, owner 0 then 1.
- Round-robin under saturation: both hold req for 10 accesses → owners strictly alternate 0,1,0,1…; 10 mem_en pulses in 20 cycles.
- Lock: cpu_lock=1 and CPU holds req across 3 accesses while DMA requests → DMA is not granted until cpu_lock drops; then DMA wins the next arbitration.
- Write then readback: DMA writes 0xBEEF to 0x0100, then CPU reads 0x0100 → mem_we=1 only in DMA's ACCESS cycle; cpu_rdata=0xBEEF; dma_rdata unchanged.
- Reset mid-access: assert rst low during ACCESS → mem_en falls asynchronously, no ack; after release, a fresh CPU request completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Provides the FSM state encoding, the requester IDs and a tiny helper
// used by the round-robin picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // The requester that is not 'id'; with two ports this is the round-robin winner.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker with exclusion and CPU lock masking.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only decides, the caller owns the handshake.
//
// Ports:
//   req[1:0]      raw requests, index 0 = CPU, index 1 = DMA
//   last          requester served most recently
//   exclude_valid drop exclude_id from consideration (its request is stale)
//   exclude_id    requester to drop when exclude_valid is set
//   lock          CPU lock; masks DMA only while the CPU was the last owner
//   valid / id    an eligible requester exists / which one wins
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       exclude_valid,
  input  logic       exclude_id,
  input  logic       lock,
  output logic       valid,
  output logic       id
);

  logic [1:0] elig;

  always_comb begin
    elig = req;
    if (exclude_valid) begin
      elig[exclude_id] = 1'b0;
    end
    if (lock && (last == OWN_CPU)) begin
      elig[OWN_DMA] = 1'b0;
    end
    valid = |elig;
    // On a tie the requester not served last wins; otherwise the lone one.
    if (&elig) begin
      id = other_id(last);
    end else begin
      id = elig[OWN_DMA];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between the CPU and a DMA requester.
// Latency: grant edge -> mem_en next cycle -> ack two cycles after the grant edge.
// Backpressure: requesters hold req until their ack; the loser waits for the next arbitration edge.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/lock    CPU request bundle (lock keeps DMA out after a CPU access)
//   cpu_ack, cpu_rdata            CPU completion pulse and held read data
//   dma_req/we/addr/wdata         DMA request bundle
//   dma_ack, dma_rdata            DMA completion pulse and held read data
//   mem_en/we/addr/wdata          registered memory command, mem_en one cycle per access
//   mem_rdata                     memory read data, valid the cycle after mem_en
//   owner, busy                   owner of current/last access; high in ACCESS and RESP
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_lock,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  state_t        state;
  state_t        state_nxt;
  logic          grant;
  logic          pick_vld;
  logic          pick_id;
  // Kept apart from 'owner' because they reset differently: owner reads 0,
  // but the CPU must win the first tie, so the last owner starts as DMA.
  logic          last_own;
  // Direction of the access in flight; mem_we itself drops after ACCESS.
  logic          acc_we;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // One picker serves both arbitration edges; in RESP the current owner's
  // request is still high from the access just finished, so it is excluded.
  rr_pick u_pick (
    .req           ({dma_req, cpu_req}),
    .last          (last_own),
    .exclude_valid (state == ST_RESP),
    .exclude_id    (owner),
    .lock          (cpu_lock),
    .valid         (pick_vld),
    .id            (pick_id)
  );

  always_comb begin
    sel_we    = (pick_id == OWN_DMA) ? dma_we    : cpu_we;
    sel_addr  = (pick_id == OWN_DMA) ? dma_addr  : cpu_addr;
    sel_wdata = (pick_id == OWN_DMA) ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_ACCESS;
          grant     = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (pick_vld) begin
          state_nxt = ST_ACCESS;
          grant     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= OWN_CPU;
      last_own  <= OWN_DMA;
      acc_we    <= 1'b0;
      busy      <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      mem_en  <= grant;
      mem_we  <= grant & sel_we;
      busy    <= (state_nxt != ST_IDLE);
      cpu_ack <= (state == ST_RESP) && (owner == OWN_CPU);
      dma_ack <= (state == ST_RESP) && (owner == OWN_DMA);

      // mem_rdata belongs to the access issued in the preceding ACCESS cycle.
      if ((state == ST_RESP) && !acc_we) begin
        if (owner == OWN_CPU) begin
          cpu_rdata <= mem_rdata;
        end else begin
          dma_rdata <= mem_rdata;
        end
      end

      if (grant) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        owner     <= pick_id;
        last_own  <= pick_id;
        acc_we    <= sel_we;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_lock, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_we, owner, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_lock  (cpu_lock),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner),
    .busy      (busy)
  );

  // Memory device: synchronous read, contents default to init_word().
  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h0040) return 16'h1234;
    return {a[7:0], ~a[7:0]} ^ 16'h0F0F;
  endfunction

  bit [15:0] mem_arr [0:4095];
  bit        mem_wr  [0:4095];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr[11:0]] <= mem_wdata;
        mem_wr[mem_addr[11:0]]  <= 1'b1;
      end
      mem_rdata <= mem_wr[mem_addr[11:0]] ? mem_arr[mem_addr[11:0]] : init_word(mem_addr);
    end
  end

  // Reference model for the random phase: expected memory contents, updated
  // in completion order (accesses are serialised, so ack order = access order).
  bit   [15:0] sh_val [0:4095];
  bit          sh_wr  [0:4095];
  logic [15:0] last_rd [2];

  function automatic logic [15:0] sh_read(input logic [15:0] a);
    return sh_wr[a[11:0]] ? sh_val[a[11:0]] : init_word(a);
  endfunction

  // Memory strobe statistics over the random phase.
  bit cnt_on  = 1'b0;
  int men_cnt = 0;
  int dbl_cnt = 0;
  bit men_prev = 1'b0;
  always @(posedge clk) begin
    if (cnt_on && mem_en) men_cnt++;
    if (cnt_on && mem_en && men_prev) dbl_cnt++;
    men_prev = mem_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit is_dma, input bit req, input bit we,
                       input logic [15:0] a, input logic [15:0] d);
    if (is_dma) begin
      dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cpu_lock = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    cpu_lock = 1'b0;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!busy && !mem_en) break;
    end
    chk({tag, " drain busy"}, 32'(busy), 32'd0);
    tick();
  endtask

  typedef struct {
    bit          is_dma;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  // Single access on an idle arbiter, checked cycle by cycle.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v.is_dma, 1'b1, v.we, v.addr, v.wdata);
    tick();
    chk({tag, " mem_en@grant"}, 32'(mem_en), 32'd1);
    chk({tag, " mem_we@grant"}, 32'(mem_we), 32'(v.we));
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.addr));
    if (v.we) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
    chk({tag, " owner"}, 32'(owner), 32'(v.is_dma));
    chk({tag, " busy@access"}, 32'(busy), 32'd1);
    tick();
    chk({tag, " mem_en@resp"}, 32'(mem_en), 32'd0);
    chk({tag, " mem_we@resp"}, 32'(mem_we), 32'd0);
    chk({tag, " acks@resp"}, 32'({cpu_ack, dma_ack}), 32'd0);
    tick();
    chk({tag, " acks@ack"}, 32'({cpu_ack, dma_ack}), v.is_dma ? 32'd1 : 32'd2);
    chk({tag, " rdata"}, 32'(v.is_dma ? dma_rdata : cpu_rdata), 32'(v.exp_rdata));
    chk({tag, " busy@ack"}, 32'(busy), 32'd0);
    drive(v.is_dma, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk({tag, " acks@after"}, 32'({cpu_ack, dma_ack}), 32'd0);
    chk({tag, " mem_en@after"}, 32'(mem_en), 32'd0);
  endtask

  task automatic rand_port(input bit is_dma, input int n);
    bit          we;
    bit          got;
    logic [15:0] a, d, exp;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      we = 1'($urandom_range(0, 1));
      a  = 16'h0800 | 16'($urandom_range(0, 15));
      d  = 16'($urandom);
      drive(is_dma, 1'b1, we, a, d);
      got = 1'b0;
      for (int t = 0; t < 12; t++) begin
        tick();
        if (is_dma ? dma_ack : cpu_ack) begin
          got = 1'b1;
          break;
        end
      end
      chk(is_dma ? "rand dma ack in time" : "rand cpu ack in time", 32'(got), 32'd1);
      if (got) begin
        if (we) begin
          sh_val[a[11:0]] = d;
          sh_wr[a[11:0]]  = 1'b1;
          chk(is_dma ? "rand dma rdata held" : "rand cpu rdata held",
              32'(is_dma ? dma_rdata : cpu_rdata), 32'(last_rd[is_dma]));
        end else begin
          exp = sh_read(a);
          chk(is_dma ? "rand dma rdata" : "rand cpu rdata",
              32'(is_dma ? dma_rdata : cpu_rdata), 32'(exp));
          last_rd[is_dma] = exp;
        end
      end
      drive(is_dma, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   ccnt, dcnt, npulse;
    bit   seen;

    vecs[0] = '{is_dma: 1'b0, we: 1'b0, addr: 16'h0040, wdata: 16'h0000, exp_rdata: 16'h1234};
    vecs[1] = '{is_dma: 1'b1, we: 1'b1, addr: 16'h0100, wdata: 16'hBEEF, exp_rdata: 16'h0000};
    vecs[2] = '{is_dma: 1'b0, we: 1'b0, addr: 16'h0100, wdata: 16'h0000, exp_rdata: 16'hBEEF};
    vecs[3] = '{is_dma: 1'b1, we: 1'b0, addr: 16'h0040, wdata: 16'h0000, exp_rdata: 16'h1234};
    vecs[4] = '{is_dma: 1'b0, we: 1'b1, addr: 16'h0040, wdata: 16'h5555, exp_rdata: 16'hBEEF};
    vecs[5] = '{is_dma: 1'b1, we: 1'b0, addr: 16'h0040, wdata: 16'h0000, exp_rdata: 16'h5555};
    vecs[6] = '{is_dma: 1'b0, we: 1'b0, addr: 16'h0040, wdata: 16'h0000, exp_rdata: 16'h5555};

    // Reset values, checked while reset is held.
    rst = 1'b1;
    cpu_lock = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst = 1'b0;
    #1;
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset acks", 32'({cpu_ack, dma_ack}), 32'd0);
    chk("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset dma_rdata", 32'(dma_rdata), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Table of isolated accesses.
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous first request out of reset: CPU first, DMA at the RESP edge.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    tick();
    chk("sim mem_en cpu", 32'(mem_en), 32'd1);
    chk("sim owner cpu", 32'(owner), 32'd0);
    chk("sim addr cpu", 32'(mem_addr), 32'h0040);
    tick();
    chk("sim mem_en gap", 32'(mem_en), 32'd0);
    chk("sim acks gap", 32'({cpu_ack, dma_ack}), 32'd0);
    tick();
    chk("sim cpu ack", 32'({cpu_ack, dma_ack}), 32'd2);
    chk("sim cpu rdata", 32'(cpu_rdata), 32'h5555);
    chk("sim mem_en dma", 32'(mem_en), 32'd1);
    chk("sim owner dma", 32'(owner), 32'd1);
    chk("sim addr dma", 32'(mem_addr), 32'h0100);
    chk("sim busy", 32'(busy), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("sim mem_en gap2", 32'(mem_en), 32'd0);
    chk("sim acks gap2", 32'({cpu_ack, dma_ack}), 32'd0);
    tick();
    chk("sim dma ack", 32'({cpu_ack, dma_ack}), 32'd1);
    chk("sim dma rdata", 32'(dma_rdata), 32'hBEEF);
    dma_req = 1'b0;
    tick();
    chk("sim idle busy", 32'(busy), 32'd0);
    chk("sim idle acks", 32'({cpu_ack, dma_ack}), 32'd0);

    // Saturation: strict alternation, one access every two cycles.
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_en) begin
        chk($sformatf("sat owner #%0d", npulse), 32'(owner), 32'(npulse % 2));
        npulse++;
      end
    end
    chk("sat mem_en count", 32'(npulse), 32'd10);
    drain("sat");

    // Lock: CPU keeps the port while locked, DMA wins once lock drops.
    do_reset();
    cpu_lock = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    ccnt = 0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_ack) ccnt++;
      if (dma_ack) dcnt++;
      if (ccnt == 3) break;
    end
    chk("lock cpu acks", 32'(ccnt), 32'd3);
    chk("lock dma acks", 32'(dcnt), 32'd0);
    cpu_lock = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("unlock grant seen", 32'(seen), 32'd1);
    chk("unlock owner dma", 32'(owner), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dma_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("unlock dma ack", 32'(seen), 32'd1);
    chk("unlock dma rdata", 32'(dma_rdata), 32'hBEEF);
    drain("lock");

    // Reset in the middle of an access.
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
    tick();
    chk("midrst mem_en before", 32'(mem_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst mem_en async", 32'(mem_en), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("midrst no ack 1", 32'(cpu_ack), 32'd0);
    tick();
    chk("midrst no ack 2", 32'(cpu_ack), 32'd0);
    rst = 1'b1;
    tick();
    chk("midrst no ack 3", 32'(cpu_ack), 32'd0);
    chk("midrst mem_en idle", 32'(mem_en), 32'd0);
    run_vec(vecs[6], "midrst fresh");

    // Random traffic from both ports against the memory-content model.
    do_reset();
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    men_cnt = 0;
    dbl_cnt = 0;
    cnt_on  = 1'b1;
    fork
      rand_port(1'b0, 60);
      rand_port(1'b1, 60);
    join
    drain("rand");
    cnt_on = 1'b0;
    chk("rand mem_en count", 32'(men_cnt), 32'd120);
    chk("rand mem_en back-to-back", 32'(dbl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
